// File: rtl/reset_conditioner_pkg.sv
// Shared types and helpers for the multi-channel reset conditioner.
package reset_conditioner_pkg;

    // Per-channel conditioner state.
    typedef enum logic [1:0] {
        StAssert   = 2'd0,
        StHold     = 2'd1,
        StReleased = 2'd2
    } ch_state_e;

    // Width of the stretch counter: enough to hold STRETCH, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned stretch);
        int unsigned w;
        w = $clog2(stretch + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reset_conditioner_ch.sv
// One reset channel: synchroniser, polarity normaliser, stretch FSM and sticky event flag.
module reset_conditioner_ch
    import reset_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STRETCH     = 8,
    parameter logic        SRC_ACT_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_src,
    input  logic i_event_clr,
    output logic o_rst,
    output logic o_rst_n,
    output logic o_event
);

    localparam int unsigned    CntW    = cnt_width(STRETCH);
    localparam int unsigned    LastVal = (STRETCH > 0) ? STRETCH - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(LastVal);
    // Raw source level that means "reset asserted".
    localparam logic           AssertLvl = ~SRC_ACT_LOW;

    logic [SYNC_STAGES-1:0] r_sync;
    ch_state_e              r_state;
    logic [CntW-1:0]        r_cnt;
    logic                   r_rst;
    logic                   r_rst_n;
    logic                   r_event;

    ch_state_e              w_state_d;
    logic [CntW-1:0]        w_cnt_d;
    logic                   w_src_act;
    logic                   w_event_set;

    // Synchroniser chain; resets to the asserted source level so outputs stay in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{AssertLvl}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_src};
        end
    end

    assign w_src_act   = SRC_ACT_LOW ? ~r_sync[SYNC_STAGES-1] : r_sync[SYNC_STAGES-1];
    assign w_event_set = (r_state == StReleased) && w_src_act;

    // Next-state and counter logic; the counter saturates at CntLast and never wraps.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StAssert: begin
                if (!w_src_act) begin
                    if (STRETCH == 0) begin
                        w_state_d = StReleased;
                    end else begin
                        w_state_d = StHold;
                        w_cnt_d   = '0;
                    end
                end
            end
            StHold: begin
                if (w_src_act) begin
                    w_state_d = StAssert;
                    w_cnt_d   = '0;
                end else if (r_cnt == CntLast) begin
                    w_state_d = StReleased;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StReleased: begin
                if (w_src_act) begin
                    w_state_d = StAssert;
                end
            end
            default: begin
                w_state_d = StAssert;
                w_cnt_d   = '0;
            end
        endcase
    end

    // State, counter, registered (glitch-free) reset outputs and sticky event flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StAssert;
            r_cnt   <= '0;
            r_rst   <= 1'b1;
            r_rst_n <= 1'b0;
            r_event <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rst   <= (w_state_d != StReleased);
            r_rst_n <= (w_state_d == StReleased);
            // A new event wins over a simultaneous clear.
            r_event <= w_event_set | (r_event & ~i_event_clr);
        end
    end

    assign o_rst   = r_rst;
    assign o_rst_n = r_rst_n;
    assign o_event = r_event;

endmodule

// File: rtl/reset_conditioner.sv
// Multi-channel reset conditioner: N_CH independent channels plus an all-released flag.
module reset_conditioner
    import reset_conditioner_pkg::*;
#(
    parameter int unsigned     N_CH        = 4,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     STRETCH     = 8,
    parameter logic [N_CH-1:0] SRC_ACT_LOW = {N_CH{1'b1}}
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N_CH-1:0] i_src,
    input  logic [N_CH-1:0] i_event_clr,
    output logic [N_CH-1:0] o_rst,
    output logic [N_CH-1:0] o_rst_n,
    output logic [N_CH-1:0] o_event,
    output logic            o_all_released
);

    if (N_CH < 1) begin : g_bad_nch
        $fatal(1, "reset_conditioner: N_CH must be >= 1");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "reset_conditioner: SYNC_STAGES must be >= 2");
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        reset_conditioner_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STRETCH     (STRETCH),
            .SRC_ACT_LOW (SRC_ACT_LOW[g])
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_src       (i_src[g]),
            .i_event_clr (i_event_clr[g]),
            .o_rst       (o_rst[g]),
            .o_rst_n     (o_rst_n[g]),
            .o_event     (o_event[g])
        );
    end

    assign o_all_released = &(~o_rst);

endmodule

// File: doc/reset_conditioner.md
Name: reset_conditioner

Overview:
Multi-channel reset conditioner. It takes N_CH reset-source inputs, each with its own polarity, into the i_clk domain. For each channel it produces a synchronised, stretched reset in both polarities. It also provides sticky reset-event flags and an all-released indication. The block sits between raw reset sources (POR, watchdog, soft-reset bits, external pins) and the reset inputs of downstream subsystems.

Parameters:
N_CH, 4, number of reset channels (>=1)
SYNC_STAGES, 2, synchroniser depth per channel (>=2)
STRETCH, 8, cycles the output stays asserted after the synchronised source releases (>=0)
SRC_ACT_LOW, all ones (N_CH bits), bit i=1: i_src[i] is active-low; bit i=0: active-high

Ports:
i_clk  input  1  clock; the single clock domain
i_rst_n  input  1  asynchronous active-low reset of the block itself
i_src  input  N_CH  raw reset sources; asynchronous to i_clk; polarity per SRC_ACT_LOW
i_event_clr  input  N_CH  per-channel clear of o_event; synchronous
o_rst  output  N_CH  conditioned reset, active-high
o_rst_n  output  N_CH  conditioned reset, active-low; always equals ~o_rst
o_event  output  N_CH  sticky flag: channel went from released to asserted
o_all_released  output  1  1 when every channel is released

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low; all flops reset on its falling edge without a clock.
- Values during and directly after reset:
  - every synchroniser flop holds the asserted level
  - each FSM is in ASSERT; counters are 0
  - o_rst = all 1, o_rst_n = all 0, o_event = 0, o_all_released = 0
- Normalisation: each synchroniser samples i_src[i] raw. Its last stage is normalised to src_act[i] = SRC_ACT_LOW[i] ? ~sync : sync.
- Per-channel FSM, states ASSERT, HOLD, RELEASED:
  - ASSERT: if src_act=0, go to HOLD with cnt=0. When STRETCH=0, go straight to RELEASED instead.
  - HOLD: if src_act=1, go to ASSERT with cnt=0. Otherwise cnt increments each cycle. When cnt==STRETCH-1, go to RELEASED.
  - RELEASED: if src_act=1, go to ASSERT.
- Counter: cnt is $clog2(STRETCH+1) bits wide (minimum 1). It never wraps.
- Outputs:
  - o_rst[i] is a flop loaded with (next_state != RELEASED), so it is glitch-free.
  - o_rst_n[i] is the complementary flop.
  - o_all_released is the combinational AND of ~o_rst.
- Latency, in i_clk edges, from a stable src change:
  - assertion: SYNC_STAGES+1
  - release: SYNC_STAGES+1+STRETCH
  - a 1-cycle source pulse gives an o_rst pulse of 1+STRETCH cycles
- Event flag: o_event[i] sets on the RELEASED->ASSERT transition and clears on i_event_clr[i]. If set and clear occur in the same cycle, set wins. Assertion caused by i_rst_n does not set the flag.
- Channels are fully independent. The only interaction is o_all_released.
- Reset mid-operation: assertion of i_rst_n at any point, including mid-HOLD, immediately forces the reset values. After i_rst_n releases, each channel starts again in ASSERT.
- Elaboration checks: SYNC_STAGES<2 or N_CH<1 is a fatal elaboration error.

Decomposition:
- Package reset_conditioner_pkg holds:
  - the FSM state enum typedef (ASSERT, HOLD, RELEASED), 2-bit
  - a function computing the counter width from STRETCH
- Sub-module reset_conditioner_ch holds one channel: synchroniser, normaliser, FSM, counter, event flag. It takes parameters SYNC_STAGES, STRETCH, SRC_ACT_LOW (1 bit).
- The top instantiates N_CH copies in a generate loop and forms o_all_released.

Test Plan:
1. Default params, i_src=4'b1111 (all released), release i_rst_n -> o_rst=4'b1111 for 10 edges, 4'b0000 at edge 11; o_all_released=1 at edge 11; o_event=0.
2. All released, i_src[1] low for exactly 1 cycle -> o_rst[1] rises 3 edges later and stays high 9 cycles; o_event[1]=1 and stays 1; other channels unaffected; o_all_released=0 throughout.
3. i_src[2] asserted and released, then reasserted on the 5th HOLD cycle -> o_rst[2] stays high; after the final release, 8 full HOLD cycles elapse before o_rst[2]=0.
4. SRC_ACT_LOW=4'b0101, i_src=4'b0000 held -> channels 0 and 2 stay asserted; channels 1 and 3 release at edge 11; o_rst_n=4'b1010; o_all_released=0.
5. o_event[0]=1, i_event_clr[0] pulsed on the same cycle as a new RELEASED->ASSERT event -> o_event[0] remains 1; the next clear alone -> 0.
6. i_rst_n dropped mid-HOLD on channel 3, no clock edge -> o_rst=4'b1111 and o_event=0 immediately. Separately, with STRETCH=0 -> release latency is 3 edges.
